// File: rtl/rc_lowpass_filter.sv
// First-order RC low-pass: y += alpha*(x - y) once per audio sample,
// using a 16-cycle serial shift-add multiply instead of a hardware multiplier.
module rc_lowpass_filter #(
  parameter int CLOCK_RATE   = 50000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 10000,
  parameter int C_35_SHIFTED = 1134
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        overrun
);

  // alpha = dt/(RC+dt) in Q16, with RC and dt both scaled by 2^35
  localparam logic [63:0] DEN =
    64'(R) * 64'(C_35_SHIFTED) * 64'(SAMPLE_RATE) + (64'd1 << 35);
  localparam logic [63:0] ALPHA_RAW = (64'd1 << 51) / DEN;
  localparam logic [15:0] ALPHA =
    (ALPHA_RAW < 64'd1)     ? 16'd1 :
    (ALPHA_RAW > 64'd65535) ? 16'hFFFF : ALPHA_RAW[15:0];

  // One sample needs 18 clocks, so the clock must outpace the sample rate by that much
  generate
    if (CLOCK_RATE < SAMPLE_RATE * 18) begin : g_rate_chk
      $error("rc_lowpass_filter: CLOCK_RATE too low for SAMPLE_RATE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t      r_state;
  logic [16:0] r_diff;
  logic [32:0] r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_y;

  logic signed [32:0] w_addend;
  logic signed [17:0] w_sum;
  logic        [15:0] w_sat;
  logic        [16:0] w_diff;

  assign w_diff   = 17'($signed({in[15], in}) - $signed({r_y[15], r_y}));
  assign w_addend = ALPHA[r_cnt] ? ($signed({{16{r_diff[16]}}, r_diff}) <<< r_cnt) : 33'sd0;
  // acc >>> 16 keeps the top 17 bits; adding into 18 bits cannot overflow
  assign w_sum    = $signed({{2{r_y[15]}}, r_y}) + $signed({r_acc[32], r_acc[32:16]});

  always_comb begin
    w_sat = w_sum[15:0];
    if (w_sum > 18'sd32767)       w_sat = 16'h7FFF;
    else if (w_sum < -18'sd32768) w_sat = 16'h8000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_diff    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (audio_clk_en) begin
            r_diff  <= w_diff;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (audio_clk_en) overrun <= 1'b1;
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= ACC;
        end
        ACC: begin
          if (audio_clk_en) overrun <= 1'b1;
          r_y       <= w_sat;
          out       <= w_sat;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_lowpass_filter.sv
// Scoreboard bench for rc_lowpass_filter: stimulus pushes expected value and
// arrival cycle, a negedge monitor pops and compares on every out_valid.
module tb_rc_lowpass_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] filt_out;
  logic        out_valid;
  logic        overrun;

  rc_lowpass_filter dut (
    .clk(clk), .rst_n(rst_n), .audio_clk_en(en), .in(sample_in),
    .out(filt_out), .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int cyc;} exp_t;
  exp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit sweep = 1'b0;
  int prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected entry
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_value", int'($signed(filt_out)), e.val);
        chk("out_latency", cyc, e.cyc);
        if (sweep) begin
          chk("monotonic", int'($signed(filt_out)) >= prev, 1);
          chk("ceiling", int'($signed(filt_out)) <= 32767, 1);
          prev = int'($signed(filt_out));
        end
      end
    end
  end

  // Reference: y + floor(3891*(x-y)/2^16), saturated to 16 bits
  function automatic int model(input int y, input int x);
    longint p, s;
    p = longint'(x - y) * 64'sd3891;
    s = longint'(y) + (p >>> 16);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // Called at a negedge; strobe lands on the next posedge
  task automatic strobe(input int x, input bit push, input int expv);
    sample_in = x[15:0];
    en = 1'b1;
    if (push) sb.push_back('{expv, cyc + 1 + 17});
    @(negedge clk);
    en = 1'b0;
    sample_in = 16'($urandom);
  endtask

  task automatic strobe_at(input int t, input int x, input bit push, input int expv);
    for (int k = 0; k < 1000 && cyc < t - 1; k++) @(negedge clk);
    strobe(x, push, expv);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int e, y;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(filt_out), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // Idle with strobe low: nothing moves
    repeat (100) @(negedge clk);
    chk("idle_out", int'(filt_out), 0);
    chk("idle_overrun", int'(overrun), 0);

    // Positive full scale step, two samples
    strobe(32767, 1'b1, 1945);
    repeat (25) @(negedge clk);
    strobe(32767, 1'b1, 3774);
    drain();
    chk("step_overrun", int'(overrun), 0);

    // Negative full scale from y=0 (floor rounding)
    do_reset();
    strobe(-32768, 1'b1, -1946);
    repeat (25) @(negedge clk);
    strobe(-32768, 1'b1, -3776);
    drain();

    // Overrun: strobes in MUL and in the ACC cycle dropped, ACC+1 accepted
    do_reset();
    e = cyc + 1;
    strobe(32767, 1'b1, 1945);
    strobe_at(e + 5, -20000, 1'b0, 0);
    strobe_at(e + 17, -20000, 1'b0, 0);
    strobe_at(e + 18, 32767, 1'b1, 3774);
    drain();
    chk("overrun_set", int'(overrun), 1);
    repeat (30) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset mid-multiply: async clear, no pulse, restart from y=0
    chk("pre_abort_out", int'($signed(filt_out)), 3774);
    e = cyc + 1;
    strobe(32767, 1'b1, 0);
    for (int k = 0; k < 100 && cyc < e + 7; k++) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_out_async", int'(filt_out), 0);
    chk("abort_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_overrun_clr", int'(overrun), 0);
    strobe(32767, 1'b1, 1945);
    drain();

    // Long sweep at full scale: monotonic approach to, never beyond, 32767
    do_reset();
    sweep = 1'b1;
    prev = 0;
    y = 0;
    for (int i = 0; i < 2000; i++) begin
      y = model(y, 32767);
      strobe(32767, 1'b1, y);
      repeat (19) @(negedge clk);
    end
    drain();
    sweep = 1'b0;
    chk("sweep_final", int'($signed(filt_out)), y);
    chk("sweep_overrun", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
